half_adder_core: RTL and testbench
==================================

# half_adder_core

Registered bitwise half-adder for the Boolean-arithmetic layer. For each of WIDTH independent lanes it computes sum = a XOR b and carry = a AND b, captures the results in an output register, and hands them downstream through a valid/ready handshake. With WIDTH=1 it is the scalar half adder used as the building block for full adders and the ALU incrementer.

## Interface
- WIDTH, default 1: number of independent 1-bit half-adder lanes; legal range 1..64.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A, lane i = bit i.
- b  input  WIDTH  operand B, lane i = bit i.
- in_valid  input  1  a/b hold a valid operand pair this cycle.
- in_ready  output  1  block accepts an operand pair this cycle.
- sum  output  WIDTH  registered a XOR b per lane.
- carry  output  WIDTH  registered a AND b per lane.
- out_valid  output  1  sum/carry hold a valid result.
- out_ready  input  1  downstream consumes the result this cycle.
- carry_count  output  $clog2(WIDTH+1)  registered popcount of carry; present only with HALF_ADDER_CARRY_COUNT_EN.

## Operation
- Lane function: sum[i] = a[i] ^ b[i], carry[i] = a[i] & b[i]. No inter-lane carry propagation.
- Truth table per lane: 00 -> sum 0, carry 0; 01 -> 1,0; 10 -> 1,0; 11 -> 0,1.
- One-entry output register. in_ready = !out_valid || out_ready (combinational).
- Accept: in_valid && in_ready at a rising edge loads sum/carry (and carry_count) from the current a/b and sets out_valid=1.
- Consume: out_valid && out_ready without a simultaneous accept clears out_valid; sum/carry keep their last values.
- Simultaneous accept and consume in one cycle: new result loaded, out_valid stays 1; full throughput of one result per cycle.
- Stall: out_valid=1, out_ready=0 -> in_ready=0, outputs frozen, a/b ignored.
- in_valid=0 while empty: registers unchanged, out_valid stays 0.
- X on a/b while in_valid=0 must not propagate into the registers.

## Timing
- Latency: exactly 1 cycle from the accepting edge to out_valid=1 with the result.
- Reset (sync, active-high, sampled on rising edge): sum=0, carry=0, carry_count=0, out_valid=0; in_ready=1 from the cycle after reset deasserts, and in_ready is 1 during reset.
- Reset asserted mid-operation: pending result discarded, same cycle-level effect as power-on reset; reset overrides a simultaneous accept.
- No combinational path from a/b to sum/carry; only in_ready depends combinationally on out_valid/out_ready.

## Configuration
- Macro HALF_ADDER_CARRY_COUNT_EN.
- Defined: carry_count port exists, loaded on every accept with the number of set bits in the new carry vector (0..WIDTH), reset to 0, frozen while stalled.
- Undefined: carry_count port and its logic are absent; all other behaviour identical.

## Test plan
- WIDTH=1, out_ready=1, apply (a,b) = 00, 01, 10, 11 one per cycle with in_valid=1 -> one cycle later (sum,carry) = 00, 10, 10, 01 with out_valid=1 each cycle.
- Reset: drive a=1,b=1,in_valid=1, then assert reset for one cycle -> next cycle sum=0, carry=0, out_valid=0, in_ready=1.
- Backpressure: accept a=1,b=0, hold out_ready=0 for 3 cycles while changing a/b -> sum=1, carry=0 held, in_ready=0; raise out_ready -> result consumed, in_ready=1.
- Simultaneous accept/consume: out_valid=1, out_ready=1, in_valid=1 with a=1,b=1 -> next cycle sum=0, carry=1, out_valid=1.
- WIDTH=8, a=0xF0, b=0x3C -> sum=0xCC, carry=0x30; with HALF_ADDER_CARRY_COUNT_EN, carry_count=2.
- Idle: in_valid=0 for 5 cycles after reset -> out_valid=0, sum=carry=0 throughout.

Source files
------------

// File: rtl/half_adder_core.sv
// Registered per-lane half adder (sum = a^b, carry = a&b) behind a one-entry valid/ready output stage.
// Optional popcount of the carry vector is enabled with the HALF_ADDER_CARRY_COUNT_EN macro.
module half_adder_core #(
  parameter int WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           sum,
  output logic [WIDTH-1:0]           carry,
  output logic                       out_valid,
  input  logic                       out_ready
`ifdef HALF_ADDER_CARRY_COUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] carry_count
`endif
);

  localparam int CW = $clog2(WIDTH+1);

  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;

  // Reset term keeps the block visibly ready while reset is held, even if a result was pending.
  assign in_ready = reset || !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      sum_d       = a ^ b;
      carry_d     = a & b;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q       <= '0;
      carry_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign out_valid = out_valid_q;

`ifdef HALF_ADDER_CARRY_COUNT_EN
  logic [CW-1:0] carry_count_q, carry_count_d;
  logic [CW-1:0] popcount;

  always_comb begin
    popcount = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popcount = popcount + CW'(a[i] & b[i]);
    end
  end

  always_comb begin
    carry_count_d = carry_count_q;
    if (accept) begin
      carry_count_d = popcount;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      carry_count_q <= '0;
    end else begin
      carry_count_q <= carry_count_d;
    end
  end

  assign carry_count = carry_count_q;
`endif

endmodule

// File: tb/tb_half_adder_core.sv
// Directed-vector bench for half_adder_core: a WIDTH=1 instance for handshake behaviour, WIDTH=8 for lane checks.
module tb_half_adder_core;

  logic       clk;
  logic       reset;
  logic       a1, b1, in_valid1, out_ready1;
  logic       in_ready1, sum1, carry1, out_valid1;
  logic [7:0] a8, b8, sum8, carry8;
  logic       in_valid8, out_ready8, in_ready8, out_valid8;
`ifdef HALF_ADDER_CARRY_COUNT_EN
  logic       cc1;
  logic [3:0] cc8;
`endif

  int checks;
  int failures;

  half_adder_core #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .a(a1), .b(b1), .in_valid(in_valid1), .in_ready(in_ready1),
    .sum(sum1), .carry(carry1), .out_valid(out_valid1), .out_ready(out_ready1)
`ifdef HALF_ADDER_CARRY_COUNT_EN
    , .carry_count(cc1)
`endif
  );

  half_adder_core #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .a(a8), .b(b8), .in_valid(in_valid8), .in_ready(in_ready8),
    .sum(sum8), .carry(carry8), .out_valid(out_valid8), .out_ready(out_ready8)
`ifdef HALF_ADDER_CARRY_COUNT_EN
    , .carry_count(cc8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a1 = 1'b1; b1 = 1'b1; in_valid1 = 1'b1; out_ready1 = 1'b0;
    a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1'b1; out_ready8 = 1'b0;
    step();
    step();
    in_valid1 = 1'b0; in_valid8 = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (sum1 !== 1'b0 || carry1 !== 1'b0 || out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      failures++;
      $display("FAIL reset_w1 got sum=%b carry=%b ov=%b ir=%b exp 0 0 0 1", sum1, carry1, out_valid1, in_ready1);
    end
    checks++;
    if (sum8 !== 8'h00 || carry8 !== 8'h00 || out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      failures++;
      $display("FAIL reset_w8 got sum=%h carry=%h ov=%b ir=%b exp 00 00 0 1", sum8, carry8, out_valid8, in_ready8);
    end
`ifdef HALF_ADDER_CARRY_COUNT_EN
    checks++;
    if (cc8 !== 4'd0) begin
      failures++;
      $display("FAIL reset_cc8 got=%0d exp=0", cc8);
    end
`endif
    $display("reset: sum=%b carry=%b out_valid=%b in_ready=%b", sum1, carry1, out_valid1, in_ready1);
  endtask

  task automatic test_idle();
    for (int i = 0; i < 5; i++) begin
      a1 = i[0]; b1 = 1'b1;
      step();
      checks++;
      if (out_valid1 !== 1'b0 || sum1 !== 1'b0 || carry1 !== 1'b0) begin
        failures++;
        $display("FAIL idle_%0d got ov=%b sum=%b carry=%b exp 0 0 0", i, out_valid1, sum1, carry1);
      end
      $display("idle %0d: out_valid=%b sum=%b carry=%b", i, out_valid1, sum1, carry1);
    end
  endtask

  task automatic test_truth_table();
    logic [1:0] vec_ab [4];
    logic [1:0] exp_sc [4];
    vec_ab = '{2'b00, 2'b01, 2'b10, 2'b11};
    exp_sc = '{2'b00, 2'b10, 2'b10, 2'b01};
    out_ready1 = 1'b1;
    in_valid1  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a1 = vec_ab[i][1];
      b1 = vec_ab[i][0];
      step();
      checks++;
      if ({sum1, carry1} !== exp_sc[i] || out_valid1 !== 1'b1) begin
        failures++;
        $display("FAIL truth_%0d got sum,carry=%b%b ov=%b exp %b ov=1", i, sum1, carry1, out_valid1, exp_sc[i]);
      end
      $display("truth a=%b b=%b: sum=%b carry=%b out_valid=%b", a1, b1, sum1, carry1, out_valid1);
    end
    in_valid1 = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    a1 = 1'b1; b1 = 1'b0; in_valid1 = 1'b1; out_ready1 = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      a1 = i[0]; b1 = 1'b1;
      #1;
      checks++;
      if (sum1 !== 1'b1 || carry1 !== 1'b0 || out_valid1 !== 1'b1 || in_ready1 !== 1'b0) begin
        failures++;
        $display("FAIL stall_%0d got sum=%b carry=%b ov=%b ir=%b exp 1 0 1 0", i, sum1, carry1, out_valid1, in_ready1);
      end
      $display("stall %0d: sum=%b carry=%b out_valid=%b in_ready=%b", i, sum1, carry1, out_valid1, in_ready1);
      step();
    end
    in_valid1 = 1'b0; out_ready1 = 1'b1;
    step();
    checks++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || sum1 !== 1'b1) begin
      failures++;
      $display("FAIL drain got ov=%b ir=%b sum=%b exp 0 1 1", out_valid1, in_ready1, sum1);
    end
    $display("drain: out_valid=%b in_ready=%b sum=%b", out_valid1, in_ready1, sum1);
  endtask

  task automatic test_back_to_back();
    a1 = 1'b0; b1 = 1'b1; in_valid1 = 1'b1; out_ready1 = 1'b1;
    step();
    a1 = 1'b1; b1 = 1'b1;
    #1;
    checks++;
    if (out_valid1 !== 1'b1 || in_ready1 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_pre got ov=%b ir=%b exp 1 1", out_valid1, in_ready1);
    end
    step();
    in_valid1 = 1'b0;
    checks++;
    if (sum1 !== 1'b0 || carry1 !== 1'b1 || out_valid1 !== 1'b1) begin
      failures++;
      $display("FAIL b2b got sum=%b carry=%b ov=%b exp 0 1 1", sum1, carry1, out_valid1);
    end
    $display("back_to_back: sum=%b carry=%b out_valid=%b", sum1, carry1, out_valid1);
  endtask

  task automatic test_reset_midop();
    out_ready1 = 1'b0; in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready1 !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", in_ready1);
    end
    step();
    reset = 1'b0; in_valid1 = 1'b0;
    #1;
    checks++;
    if (sum1 !== 1'b0 || carry1 !== 1'b0 || out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      failures++;
      $display("FAIL reset_midop got sum=%b carry=%b ov=%b ir=%b exp 0 0 0 1", sum1, carry1, out_valid1, in_ready1);
    end
    $display("reset_midop: sum=%b carry=%b out_valid=%b in_ready=%b", sum1, carry1, out_valid1, in_ready1);
  endtask

  task automatic test_wide();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] es [3];
    logic [7:0] ec [3];
    logic [3:0] en [3];
    va = '{8'hF0, 8'hFF, 8'h55};
    vb = '{8'h3C, 8'hFF, 8'hAA};
    es = '{8'hCC, 8'h00, 8'hFF};
    ec = '{8'h30, 8'hFF, 8'h00};
    en = '{4'd2, 4'd8, 4'd0};
    out_ready8 = 1'b1; in_valid8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a8 = va[i]; b8 = vb[i];
      step();
      checks++;
      if (sum8 !== es[i] || carry8 !== ec[i] || out_valid8 !== 1'b1) begin
        failures++;
        $display("FAIL wide_%0d got sum=%h carry=%h ov=%b exp %h %h 1", i, sum8, carry8, out_valid8, es[i], ec[i]);
      end
`ifdef HALF_ADDER_CARRY_COUNT_EN
      checks++;
      if (cc8 !== en[i]) begin
        failures++;
        $display("FAIL wide_cc_%0d got=%0d exp=%0d", i, cc8, en[i]);
      end
`endif
      $display("wide a=%h b=%h: sum=%h carry=%h out_valid=%b", a8, b8, sum8, carry8, out_valid8);
    end
    in_valid8 = 1'b0;
    a8 = 8'hxx; b8 = 8'hxx;
    step();
    checks++;
    if (sum8 !== 8'hFF || carry8 !== 8'h00 || out_valid8 !== 1'b0) begin
      failures++;
      $display("FAIL wide_xhold got sum=%h carry=%h ov=%b exp ff 00 0", sum8, carry8, out_valid8);
    end
    $display("wide x-hold: sum=%h carry=%h out_valid=%b", sum8, carry8, out_valid8);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_idle();
    test_truth_table();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
